// File: rtl/zap_regf_wr_sched.sv
// Write scheduler for a double-pumped register file. Two write request
// ports feed a small FIFO. The RAM alternates READ/WRITE phases on every
// i_clk_2x edge: up to two queued writes are staged during a READ cycle and
// issued to the 2-write-port RAM in the following WRITE cycle.
module zap_regf_wr_sched #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk_2x,
  input  logic        i_reset,
  input  logic        i_val_a,
  input  logic [5:0]  i_addr_a,
  input  logic [31:0] i_data_a,
  input  logic        i_val_b,
  input  logic [5:0]  i_addr_b,
  input  logic [31:0] i_data_b,
  output logic        o_rdy_a,
  output logic        o_rdy_b,
  output logic        o_wen,
  output logic [5:0]  o_wr_addr_a,
  output logic [5:0]  o_wr_addr_b,
  output logic [31:0] o_wr_data_a,
  output logic [31:0] o_wr_data_b,
  output logic        o_phase,
  input  logic [5:0]  i_chk_addr,
  output logic        o_chk_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] RDY_A_MAX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RDY_B_MAX = CW'(DEPTH - 2);

  logic [5:0]    addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          phase_r;
  logic          wen_r;
  logic [5:0]    stg_addr_a_r;
  logic [5:0]    stg_addr_b_r;
  logic [31:0]   stg_data_a_r;
  logic [31:0]   stg_data_b_r;

  logic          push_a_s;
  logic          push_b_s;
  logic [1:0]    npush_s;
  logic [1:0]    npop_s;
  logic [AW-1:0] wptr_b_s;
  logic [AW-1:0] rptr1_s;
  logic          hit_s;

  // Ready comes only from the registered count, so a pop in the same
  // cycle never lets an extra request in.
  assign o_rdy_a  = (count_r <= RDY_A_MAX);
  assign o_rdy_b  = (count_r <= RDY_B_MAX);
  assign push_a_s = i_val_a & o_rdy_a;
  assign push_b_s = i_val_b & o_rdy_b;
  assign npush_s  = {1'b0, push_a_s} + {1'b0, push_b_s};
  // B lands behind A when both are accepted, so A is the older entry.
  assign wptr_b_s = push_a_s ? (wptr_r + AW'(1)) : wptr_r;
  assign rptr1_s  = rptr_r + AW'(1);

  // Pop up to two entries in every READ-phase cycle, none in WRITE cycles.
  always_comb begin
    npop_s = 2'd0;
    if (!phase_r) begin
      if (count_r >= CW'(2)) begin
        npop_s = 2'd2;
      end else begin
        npop_s = count_r[1:0];
      end
    end else begin
      npop_s = 2'd0;
    end
  end

  // Hazard lookup: live FIFO slots plus the staged pair until it is issued.
  always_comb begin
    hit_s = wen_r & ((stg_addr_a_r == i_chk_addr) | (stg_addr_b_r == i_chk_addr));
    for (int j = 0; j < DEPTH; j++) begin
      if (({1'b0, AW'(j) - rptr_r} < count_r) && (addr_mem_r[j] == i_chk_addr)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign o_chk_hit = hit_s;

  // FIFO storage: accepted requests are written at the write pointer.
  always_ff @(posedge i_clk_2x or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= 6'd0;
        data_mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_a_s) begin
        addr_mem_r[wptr_r] <= i_addr_a;
        data_mem_r[wptr_r] <= i_data_a;
      end
      if (push_b_s) begin
        addr_mem_r[wptr_b_s] <= i_addr_b;
        data_mem_r[wptr_b_s] <= i_data_b;
      end
    end
  end

  // Pointers and occupancy; pushes and pops in one cycle both apply.
  always_ff @(posedge i_clk_2x or posedge i_reset) begin
    if (i_reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      wptr_r  <= wptr_r + AW'(npush_s);
      rptr_r  <= rptr_r + AW'(npop_s);
      count_r <= count_r + CW'(npush_s) - CW'(npop_s);
    end
  end

  // Phase toggle, staging of popped entries and the write-enable pulse.
  always_ff @(posedge i_clk_2x or posedge i_reset) begin
    if (i_reset) begin
      phase_r      <= 1'b0;
      wen_r        <= 1'b0;
      stg_addr_a_r <= 6'd0;
      stg_addr_b_r <= 6'd0;
      stg_data_a_r <= 32'd0;
      stg_data_b_r <= 32'd0;
    end else begin
      phase_r <= ~phase_r;
      if (!phase_r) begin
        wen_r <= (npop_s != 2'd0);
        case (npop_s)
          2'd2: begin
            // Same target twice: the younger write wins on both ports.
            if (addr_mem_r[rptr_r] == addr_mem_r[rptr1_s]) begin
              stg_addr_a_r <= addr_mem_r[rptr1_s];
              stg_data_a_r <= data_mem_r[rptr1_s];
            end else begin
              stg_addr_a_r <= addr_mem_r[rptr_r];
              stg_data_a_r <= data_mem_r[rptr_r];
            end
            stg_addr_b_r <= addr_mem_r[rptr1_s];
            stg_data_b_r <= data_mem_r[rptr1_s];
          end
          2'd1: begin
            stg_addr_a_r <= addr_mem_r[rptr_r];
            stg_data_a_r <= data_mem_r[rptr_r];
            stg_addr_b_r <= addr_mem_r[rptr_r];
            stg_data_b_r <= data_mem_r[rptr_r];
          end
          default: begin
            stg_addr_a_r <= stg_addr_a_r;
            stg_data_a_r <= stg_data_a_r;
            stg_addr_b_r <= stg_addr_b_r;
            stg_data_b_r <= stg_data_b_r;
          end
        endcase
      end else begin
        wen_r <= 1'b0;
      end
    end
  end

  assign o_phase     = phase_r;
  assign o_wen       = wen_r;
  assign o_wr_addr_a = stg_addr_a_r;
  assign o_wr_addr_b = stg_addr_b_r;
  assign o_wr_data_a = stg_data_a_r;
  assign o_wr_data_b = stg_data_b_r;

endmodule

// File: tb/tb_zap_regf_wr_sched.sv
// Self-checking bench for zap_regf_wr_sched: accepted requests are pushed to
// a scoreboard queue and popped in READ-phase cycles to predict the staged
// RAM writes, ready flags, write pulses and hazard hits cycle by cycle.
module tb_zap_regf_wr_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_val_a, i_val_b;
  logic [5:0]  i_addr_a, i_addr_b, i_chk_addr;
  logic [31:0] i_data_a, i_data_b;
  logic        o_rdy_a, o_rdy_b, o_wen, o_phase, o_chk_hit;
  logic [5:0]  o_wr_addr_a, o_wr_addr_b;
  logic [31:0] o_wr_data_a, o_wr_data_b;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        sb_q[$];
  logic        m_phase;
  logic        m_wen;
  logic [5:0]  m_aa, m_ab;
  logic [31:0] m_da, m_db;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pulses_exp = 0;
  int          n_pulses_seen = 0;
  int          base;

  always #5 clk = ~clk;

  zap_regf_wr_sched #(.DEPTH(DEPTH)) dut (
    .i_clk_2x    (clk),
    .i_reset     (i_reset),
    .i_val_a     (i_val_a),
    .i_addr_a    (i_addr_a),
    .i_data_a    (i_data_a),
    .i_val_b     (i_val_b),
    .i_addr_b    (i_addr_b),
    .i_data_b    (i_data_b),
    .o_rdy_a     (o_rdy_a),
    .o_rdy_b     (o_rdy_b),
    .o_wen       (o_wen),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b),
    .o_wr_data_a (o_wr_data_a),
    .o_wr_data_b (o_wr_data_b),
    .o_phase     (o_phase),
    .i_chk_addr  (i_chk_addr),
    .o_chk_hit   (o_chk_hit)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, compare against the model, then advance the model
  // across the next rising edge.
  task automatic step(input logic va, input logic [5:0] aa, input logic [31:0] da,
                      input logic vb, input logic [5:0] ab, input logic [31:0] db,
                      input logic [5:0] chk);
    int   cnt;
    int   n;
    logic acc_a, acc_b, hit;
    ent_t eo, ey, e;
    i_val_a = va; i_addr_a = aa; i_data_a = da;
    i_val_b = vb; i_addr_b = ab; i_data_b = db;
    i_chk_addr = chk;
    #1;
    cnt = sb_q.size();
    hit = m_wen && ((m_aa == chk) || (m_ab == chk));
    foreach (sb_q[k]) if (sb_q[k].addr == chk) hit = 1'b1;
    check_val("phase", 64'(o_phase), 64'(m_phase));
    check_val("wen", 64'(o_wen), 64'(m_wen));
    check_val("rdy_a", 64'(o_rdy_a), 64'(cnt <= DEPTH - 1));
    check_val("rdy_b", 64'(o_rdy_b), 64'(cnt <= DEPTH - 2));
    check_val("chk_hit", 64'(o_chk_hit), 64'(hit));
    check_val("wr_addr_a", 64'(o_wr_addr_a), 64'(m_aa));
    check_val("wr_addr_b", 64'(o_wr_addr_b), 64'(m_ab));
    check_val("wr_data_a", 64'(o_wr_data_a), 64'(m_da));
    check_val("wr_data_b", 64'(o_wr_data_b), 64'(m_db));
    if (o_wen) n_pulses_seen++;
    acc_a = va && (cnt <= DEPTH - 1);
    acc_b = vb && (cnt <= DEPTH - 2);
    if (!m_phase) begin
      n = (cnt > 2) ? 2 : cnt;
      if (n == 2) begin
        eo = sb_q.pop_front();
        ey = sb_q.pop_front();
        m_ab = ey.addr; m_db = ey.data;
        if (eo.addr == ey.addr) begin
          m_aa = ey.addr; m_da = ey.data;
        end else begin
          m_aa = eo.addr; m_da = eo.data;
        end
      end else if (n == 1) begin
        eo = sb_q.pop_front();
        m_aa = eo.addr; m_da = eo.data;
        m_ab = eo.addr; m_db = eo.data;
      end
      m_wen = (n > 0);
      if (n > 0) n_pulses_exp++;
    end else begin
      m_wen = 1'b0;
    end
    if (acc_a) begin e.addr = aa; e.data = da; sb_q.push_back(e); end
    if (acc_b) begin e.addr = ab; e.data = db; sb_q.push_back(e); end
    m_phase = ~m_phase;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic [5:0] chk);
    for (int i = 0; i < cycles; i++) step(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, chk);
  endtask

  // Assert reset away from the clock edge, check outputs at once, release
  // at a falling edge and clear the model.
  task automatic do_reset(input logic [5:0] chk);
    #2;
    i_reset = 1'b1;
    i_val_a = 1'b0;
    i_val_b = 1'b0;
    i_chk_addr = chk;
    #1;
    check_val("rst_phase", 64'(o_phase), 64'd0);
    check_val("rst_wen", 64'(o_wen), 64'd0);
    check_val("rst_rdy_a", 64'(o_rdy_a), 64'd1);
    check_val("rst_rdy_b", 64'(o_rdy_b), 64'd1);
    check_val("rst_chk_hit", 64'(o_chk_hit), 64'd0);
    check_val("rst_addr_a", 64'(o_wr_addr_a), 64'd0);
    check_val("rst_addr_b", 64'(o_wr_addr_b), 64'd0);
    check_val("rst_data_a", 64'(o_wr_data_a), 64'd0);
    check_val("rst_data_b", 64'(o_wr_data_b), 64'd0);
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    sb_q.delete();
    m_phase = 1'b0; m_wen = 1'b0;
    m_aa = 6'd0; m_ab = 6'd0; m_da = 32'd0; m_db = 32'd0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_val_a = 1'b0; i_val_b = 1'b0;
    i_addr_a = 6'd0; i_addr_b = 6'd0;
    i_data_a = 32'd0; i_data_b = 32'd0;
    i_chk_addr = 6'd0;
    do_reset(6'd0);

    // Single write from port A.
    base = n_pulses_seen;
    step(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0, 6'd5);
    idle(6, 6'd5);
    check_val("single_pulses", 64'(n_pulses_seen - base), 64'd1);

    // Dual write, different addresses.
    base = n_pulses_seen;
    step(1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 6'd2);
    idle(6, 6'd1);
    check_val("dual_pulses", 64'(n_pulses_seen - base), 64'd1);

    // Collision: younger B wins on both ports.
    step(1'b1, 6'd7, 32'hAAAA, 1'b1, 6'd7, 32'hBBBB, 6'd7);
    idle(6, 6'd7);

    // Hazard tracking on a matching and a non-matching address.
    step(1'b1, 6'd9, 32'h9999, 1'b0, 6'd0, 32'd0, 6'd9);
    idle(6, 6'd9);
    step(1'b1, 6'd9, 32'h9A9A, 1'b0, 6'd0, 32'd0, 6'd10);
    idle(6, 6'd10);

    // Saturate the FIFO with both ports, then with port A alone.
    for (int i = 0; i < 6; i++)
      step(1'b1, 6'($urandom_range(0, 15)), $urandom, 1'b1, 6'($urandom_range(0, 15)), $urandom,
           6'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++)
      step(1'b1, 6'($urandom_range(0, 15)), $urandom, 1'b0, 6'd0, 32'd0, 6'($urandom_range(0, 15)));
    idle(6, 6'd0);

    // Random traffic with a narrow address range to provoke collisions.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
           6'($urandom_range(0, 7)));
    idle(6, 6'd0);
    check_val("pulse_total", 64'(n_pulses_seen), 64'(n_pulses_exp));

    // Reset with three entries in flight: nothing may be written afterwards.
    do_reset(6'd0);
    step(1'b1, 6'd3, 32'h33, 1'b1, 6'd4, 32'h44, 6'd3);
    step(1'b1, 6'd5, 32'h55, 1'b0, 6'd0, 32'd0, 6'd3);
    do_reset(6'd3);
    base = n_pulses_seen;
    idle(8, 6'd3);
    check_val("post_reset_pulses", 64'(n_pulses_seen - base), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/zap_regf_wr_sched.md
ZAP_REGF_WR_SCHED -- requirements
Module: zap_regf_wr_sched

Interface
REQ-001 Parameter DEPTH, default 4, write-queue entries; SHALL be power of 2, >=2.
REQ-002 i_clk_2x  in  1  sole clock; the register-file RAM clock.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_val_a / i_val_b  in  1 each  write request valid, port A (higher priority) / port B.
REQ-005 i_addr_a / i_addr_b  in  6 each  register-file write address.
REQ-006 i_data_a / i_data_b  in  32 each  write data.
REQ-007 o_rdy_a / o_rdy_b  out  1 each  request accepted when valid and ready are both high.
REQ-008 o_wen  out  1  write enable to the 2-write-port register-file RAM.
REQ-009 o_wr_addr_a / o_wr_addr_b  out  6 each  RAM write addresses.
REQ-010 o_wr_data_a / o_wr_data_b  out  32 each  RAM write data.
REQ-011 o_phase  out  1  current RAM phase: 0 = READ, 1 = WRITE.
REQ-012 i_chk_addr  in  6  read address to check against pending writes.
REQ-013 o_chk_hit  out  1  high when any queued or staged write targets i_chk_addr.

Function
REQ-014 Phase register SHALL toggle every cycle, 0 on reset; o_phase drives it directly, keeping it aligned with the RAM's own phase.
REQ-015 Queue is a DEPTH-entry FIFO of {addr, data} with registered count 0..DEPTH.
REQ-016 o_rdy_a = (count <= DEPTH-1); o_rdy_b = (count <= DEPTH-2); both from the registered count only; same-cycle pops SHALL NOT raise ready.
REQ-017 Accepted A and B in one cycle SHALL both enqueue, A older than B.
REQ-018 Pop: on each cycle with phase==READ, pop min(count,2) entries into staging registers; pops and pushes in one cycle SHALL both apply to count.
REQ-019 On the following phase==WRITE cycle: o_wen=1 iff >=1 entry was staged; otherwise o_wen=0.
REQ-020 Two staged entries, different addresses: port a = older, port b = younger.
REQ-021 Two staged entries, same address: both ports SHALL carry the younger entry (younger wins, older dropped).
REQ-022 One staged entry: both ports SHALL carry that entry.
REQ-023 o_wen SHALL be 0 in every phase==READ cycle; address/data outputs hold staged values and change only at staging.
REQ-024 Queue-to-RAM latency: a request accepted at cycle t is written no earlier than t+2 and, with count<=2 at acceptance, no later than t+4.
REQ-025 o_chk_hit combinational: compare i_chk_addr against all valid FIFO entries plus staged entries whose write has not yet been issued.
REQ-026 Full FIFO: no accepts; pops continue normally. Empty FIFO: no pops, no staged entries, o_wen stays 0.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 On i_reset: phase=0, count=0, pointers=0, staging invalid, o_wen=0, all addr/data outputs 0; o_rdy_a=o_rdy_b=1.
REQ-029 Reset mid-operation SHALL discard all queued and staged writes; no o_wen pulse after reset asserts.

Verification
REQ-030 Single write: after reset, A writes addr 5, data 0xDEADBEEF -> o_wen=1 within 4 cycles in a WRITE phase; both ports addr 5 / 0xDEADBEEF; exactly one pulse.
REQ-031 Dual write: A addr 1 / 0x11, B addr 2 / 0x22, same cycle -> one o_wen pulse with port a = 1/0x11, port b = 2/0x22.
REQ-032 Collision: A addr 7 / 0xAAAA, B addr 7 / 0xBBBB, same cycle -> both ports 7/0xBBBB.
REQ-033 Full: DEPTH=4, hold A valid with o_wen-side draining blocked by back-to-back pushes -> o_rdy_b low at count 3, o_rdy_a low at count 4; no entry lost or duplicated (scoreboard vs. RAM model).
REQ-034 Hazard: queue addr 9, drive i_chk_addr=9 -> o_chk_hit=1 until the WRITE cycle issuing addr 9 completes, then 0; i_chk_addr=10 -> 0 throughout.
REQ-035 Reset mid-flight: 3 entries queued, pulse i_reset -> all outputs per REQ-028 immediately; no subsequent o_wen without new requests.
